// File: rtl/cc_scheduler.sv
// Clock-compensation scheduler: periodically reserves the TX lanes for a
// fixed-length CC sequence, back-pressuring user AXI-stream data meanwhile.
module cc_scheduler #(
  parameter int unsigned CC_PERIOD = 5000,
  parameter int unsigned CC_LENGTH = 6,
  parameter int unsigned CNT_SIZE  = 16,
  // Derived widths; CC_LENGTH = 1 would otherwise give a zero-width index.
  localparam int unsigned PW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1,
  localparam int unsigned IW = (CC_LENGTH > 1) ? $clog2(CC_LENGTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_finished,
  input  logic                force_cc,
  input  logic                axi_valid,
  input  logic                axi_last,
  output logic                axi_ready,
  output logic                cc_active,
  output logic [IW-1:0]       cc_symbol_idx,
  output logic                frame_open,
  output logic [CNT_SIZE-1:0] cc_count
);

  localparam logic [PW-1:0] PMAX = PW'(CC_PERIOD - 1);
  localparam logic [IW-1:0] IMAX = IW'(CC_LENGTH - 1);

  typedef enum logic [1:0] {StOff, StRun, StCc} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                frame_q, frame_d;
  logic [CNT_SIZE-1:0] count_q, count_d;
  logic                force_q, force_d;
  logic                pend_q, pend_d;

  logic          pcnt_wrap;
  logic [PW-1:0] pcnt_inc;
  logic          accept;

  assign axi_ready     = (state_q == StRun);
  assign cc_active     = (state_q == StCc);
  assign cc_symbol_idx = idx_q;
  assign frame_open    = frame_q;
  assign cc_count      = count_q;

  assign pcnt_wrap = (pcnt_q == PMAX);
  assign pcnt_inc  = pcnt_wrap ? '0 : pcnt_q + 1'b1;
  assign accept    = axi_valid & axi_ready;

  // Next-state: mode transitions, period counter, force/pending latches, frame tracking.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    count_d = count_q;
    force_d = force_q;
    pend_d  = pend_q;
    if (!init_finished) begin
      // Channel lost: drop everything except the completed-sequence count.
      state_d = StOff;
      pcnt_d  = '0;
      idx_d   = '0;
      frame_d = 1'b0;
      force_d = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (accept) frame_d = ~axi_last;
      unique case (state_q)
        StOff: begin
          state_d = StRun;
          pcnt_d  = '0;
        end
        StRun: begin
          pcnt_d = pcnt_inc;
          if (pcnt_wrap || force_q || pend_q) begin
            // A force_cc arriving on a start edge is absorbed by that start.
            state_d = StCc;
            idx_d   = '0;
            force_d = 1'b0;
            pend_d  = 1'b0;
            if (force_q) pcnt_d = '0;
          end else if (force_cc) begin
            force_d = 1'b1;
          end
        end
        StCc: begin
          pcnt_d = pcnt_inc;
          if (force_cc) force_d = 1'b1;
          // Periodic slot falling inside a CC is owed, not dropped.
          if (pcnt_wrap) pend_d = 1'b1;
          if (idx_q == IMAX) begin
            state_d = StRun;
            idx_d   = '0;
            count_d = count_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      pcnt_q  <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
      count_q <= '0;
      force_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      count_q <= count_d;
      force_q <= force_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_cc_scheduler.sv
// Self-checking bench for cc_scheduler: timeline model plus directed literal checks.
module tb_cc_scheduler;

  localparam int P = 16;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_finished = 1'b0;
  logic        force_cc = 1'b0;
  logic        axi_valid = 1'b0;
  logic        axi_last = 1'b0;
  logic        axi_ready;
  logic        cc_active;
  logic [1:0]  cc_symbol_idx;
  logic        frame_open;
  logic [15:0] cc_count;

  cc_scheduler #(.CC_PERIOD(P), .CC_LENGTH(L), .CNT_SIZE(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_finished (init_finished),
    .force_cc      (force_cc),
    .axi_valid     (axi_valid),
    .axi_last      (axi_last),
    .axi_ready     (axi_ready),
    .cc_active     (cc_active),
    .cc_symbol_idx (cc_symbol_idx),
    .frame_open    (frame_open),
    .cc_count      (cc_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: absolute cycle count with a period origin; a periodic slot is the
  // last cycle of each P-cycle window measured from the origin.
  int cyc = 0;
  int origin = 0;
  int cc_left = 0;
  int m_idx = 0;
  int m_count = 0;
  bit m_on = 0;
  bit m_force = 0;
  bit m_owed = 0;
  bit m_frame = 0;

  task automatic model_step();
    int  ph;
    bit  start;
    if (!init_finished) begin
      m_on = 0; cc_left = 0; m_idx = 0; m_frame = 0; m_force = 0; m_owed = 0;
    end else if (!m_on) begin
      m_on = 1;
      origin = cyc + 1;
    end else begin
      ph = (cyc - origin) % P;
      if (axi_valid && cc_left == 0) m_frame = !axi_last;
      if (cc_left > 0) begin
        if (ph == P - 1) m_owed = 1;
        if (force_cc) m_force = 1;
        cc_left--;
        if (cc_left == 0) begin
          m_count++;
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end else begin
        start = (ph == P - 1) || m_force || m_owed;
        if (start) begin
          if (m_force) origin = cyc + 1;
          cc_left = L;
          m_idx = 0;
          m_force = 0;
          m_owed = 0;
        end else if (force_cc) begin
          m_force = 1;
        end
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_on = 0; cc_left = 0; m_idx = 0; m_frame = 0; m_force = 0; m_owed = 0; m_count = 0;
      if (clk) cyc++;
    end else begin
      model_step();
    end
  end

  // Compare DUT against the model mid-cycle, every cycle.
  initial forever begin
    @(negedge clk);
    check("m_ready",  32'(axi_ready),     (m_on && cc_left == 0) ? 1 : 0);
    check("m_active", 32'(cc_active),     (cc_left > 0) ? 1 : 0);
    check("m_idx",    32'(cc_symbol_idx), m_idx);
    check("m_frame",  32'(frame_open),    32'(m_frame));
    check("m_count",  32'(cc_count),      m_count % 65536);
  end

  // Stimulus helpers: rc is the cycle index since the last entry into RUN.
  int rc = 0;
  int beats = 0;
  int win_beats = 0;
  bit auto_last = 1;

  task automatic step();
    @(negedge clk);
    rc++;
    axi_last = auto_last && (beats % 5 == 4);
    if (axi_valid && axi_ready) begin
      beats++;
      if (rc >= 35 && rc <= 50) win_beats++;
    end
  endtask

  task automatic goto_cycle(input int n);
    while (rc < n) step();
  endtask

  task automatic start_run();
    init_finished = 1'b1;
    rc = -1;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready",  32'(axi_ready), 0);
    check("rst_active", 32'(cc_active), 0);
    check("rst_idx",    32'(cc_symbol_idx), 0);
    check("rst_frame",  32'(frame_open), 0);
    check("rst_count",  32'(cc_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    axi_valid = 1'b1;
    #12;
    check("por_ready",  32'(axi_ready), 0);
    check("por_active", 32'(cc_active), 0);
    check("por_count",  32'(cc_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Periodic CC timing and beat throughput.
    start_run();
    check("t1_ready0", 32'(axi_ready), 1);
    goto_cycle(15); check("t1_act15", 32'(cc_active), 0);
    goto_cycle(16); check("t1_act16", 32'(cc_active), 1);
    goto_cycle(17); check("t1_frame17", 32'(frame_open), 1);
    goto_cycle(18); check("t1_act18", 32'(cc_active), 1);
    goto_cycle(19); check("t1_act19", 32'(cc_active), 0);
    check("t1_count19", 32'(cc_count), 1);
    goto_cycle(32); check("t1_act32", 32'(cc_active), 1);
    goto_cycle(34); check("t1_act34", 32'(cc_active), 1);
    goto_cycle(35); check("t1_count35", 32'(cc_count), 2);
    goto_cycle(48); check("t2_frame48", 32'(frame_open), 1);
    check("t2_ready48", 32'(axi_ready), 0);
    goto_cycle(51); check("t2_beats", win_beats, 13);

    // Asynchronous reset mid-frame.
    check("t6_frame_pre", 32'(frame_open), 1);
    auto_last = 0;
    init_finished = 1'b0;
    do_reset();

    // Forced CC, then force coincident with a periodic slot.
    start_run();
    goto_cycle(5); force_cc = 1'b1;
    goto_cycle(6); force_cc = 1'b0;
    check("t3_act6", 32'(cc_active), 0);
    goto_cycle(7); check("t3_act7", 32'(cc_active), 1);
    goto_cycle(9); check("t3_act9", 32'(cc_active), 1);
    goto_cycle(10); check("t3_act10", 32'(cc_active), 0);
    check("t3_count10", 32'(cc_count), 1);
    goto_cycle(16); check("t3_act16", 32'(cc_active), 0);
    goto_cycle(22); check("t3_act22", 32'(cc_active), 0);
    goto_cycle(23); check("t3_act23", 32'(cc_active), 1);
    goto_cycle(26); check("t3_count26", 32'(cc_count), 2);
    goto_cycle(38); force_cc = 1'b1;
    goto_cycle(39); force_cc = 1'b0;
    check("t4_act39", 32'(cc_active), 1);
    goto_cycle(41); check("t4_act41", 32'(cc_active), 1);
    goto_cycle(42); check("t4_act42", 32'(cc_active), 0);
    check("t4_count42", 32'(cc_count), 3);
    goto_cycle(43); check("t4_act43", 32'(cc_active), 0);
    goto_cycle(54); check("t4_act54", 32'(cc_active), 0);
    goto_cycle(55); check("t4_act55", 32'(cc_active), 1);

    // Drop init mid-CC, then re-initialise.
    goto_cycle(56);
    check("t5_idx56", 32'(cc_symbol_idx), 1);
    check("t5_frame56", 32'(frame_open), 1);
    init_finished = 1'b0;
    goto_cycle(57);
    check("t5_act57", 32'(cc_active), 0);
    check("t5_ready57", 32'(axi_ready), 0);
    check("t5_frame57", 32'(frame_open), 0);
    check("t5_count57", 32'(cc_count), 3);
    goto_cycle(60); check("t5_count60", 32'(cc_count), 3);
    start_run();
    check("t5_ready0", 32'(axi_ready), 1);
    goto_cycle(15); check("t5_act15", 32'(cc_active), 0);
    goto_cycle(16); check("t5_act16", 32'(cc_active), 1);
    goto_cycle(19); check("t5_count19", 32'(cc_count), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
